kogge_stone_pipe: RTL and testbench

KOGGE_STONE_PIPE -- requirements
Module: kogge_stone_pipe

---
 rtl/kogge_stone_pipe.sv | 133 +++++++++++++
 tb/tb_kogge_stone_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder with an optional lower-part-OR approximation.
// One prefix level per register stage; a single global stall holds every stage.
module kogge_stone_pipe #(
  parameter int WIDTH      = 16,
  parameter int APPROX_MAX = 8,
  parameter int KW         = $clog2(APPROX_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [KW-1:0]    approx_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [31:0]      op_count
);

  localparam int LOG = $clog2(WIDTH);

  // Stage s in 0..LOG holds operands and prefix state; stage LOG+1 holds the result.
  logic [LOG+1:0]   r_valid;
  logic [WIDTH-1:0] r_a [0:LOG];
  logic [WIDTH-1:0] r_b [0:LOG];
  logic [WIDTH-1:0] r_g [0:LOG];
  logic [WIDTH-1:0] r_p [0:LOG];
  logic [KW-1:0]    r_k [0:LOG];
  logic [LOG:0]     r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [31:0]      r_op_count;

  logic             w_adv;
  logic [KW-1:0]    w_k0;
  logic [WIDTH-1:0] w_lo0;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_p0;
  logic             w_cin0;
  logic [WIDTH-1:0] w_gl [1:LOG];
  logic [WIDTH-1:0] w_pl [1:LOG];
  logic [WIDTH-1:0] w_lo_f;
  logic [WIDTH-1:0] w_cvec;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_adv     = !(r_valid[LOG+1] && !out_ready);
  assign in_ready  = !rst && w_adv;
  assign out_valid = r_valid[LOG+1];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign op_count  = r_op_count;

  // Approximated bits are neutralised in the prefix tree; only bit k-1 may
  // generate, which becomes the carry into bit k. cin is dropped when k>0.
  assign w_k0   = (approx_k > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : approx_k;
  assign w_lo0  = (WIDTH'(1) << w_k0) - WIDTH'(1);
  assign w_p0   = (a ^ b) & ~w_lo0;
  assign w_g0   = (a & b) & ~(w_lo0 >> 1);
  assign w_cin0 = (w_k0 == '0) ? cin : 1'b0;

  genvar gi, gj;
  generate
    for (gi = 1; gi <= LOG; gi++) begin : g_level
      localparam int SPAN = 1 << (gi - 1);
      logic [WIDTH-1:0] w_g;
      logic [WIDTH-1:0] w_p;
      for (gj = 0; gj < WIDTH; gj++) begin : g_bit
        if (gj < SPAN) begin : g_pass
          assign w_g[gj] = r_g[gi-1][gj];
          assign w_p[gj] = r_p[gi-1][gj];
        end else begin : g_merge
          assign w_g[gj] = r_g[gi-1][gj] | (r_p[gi-1][gj] & r_g[gi-1][gj-SPAN]);
          assign w_p[gj] = r_p[gi-1][gj] & r_p[gi-1][gj-SPAN];
        end
      end
      assign w_gl[gi] = w_g;
      assign w_pl[gi] = w_p;
    end
  endgenerate

  // Group G/P at the last prefix level span bits [i:0]; fold in cin for carries.
  assign w_lo_f  = (WIDTH'(1) << r_k[LOG]) - WIDTH'(1);
  assign w_cvec  = r_g[LOG] | (r_p[LOG] & {WIDTH{r_cin[LOG]}});
  assign w_carry = {w_cvec[WIDTH-2:0], r_cin[LOG]};
  assign w_sum   = (w_lo_f & (r_a[LOG] | r_b[LOG]))
                 | (~w_lo_f & (r_a[LOG] ^ r_b[LOG] ^ w_carry));
  assign w_cout  = w_cvec[WIDTH-1];

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a[0]   <= a;
      r_b[0]   <= b;
      r_k[0]   <= w_k0;
      r_cin[0] <= w_cin0;
      r_g[0]   <= w_g0;
      r_p[0]   <= w_p0;
      for (int s = 1; s <= LOG; s++) begin
        r_a[s]   <= r_a[s-1];
        r_b[s]   <= r_b[s-1];
        r_k[s]   <= r_k[s-1];
        r_cin[s] <= r_cin[s-1];
        r_g[s]   <= w_gl[s];
        r_p[s]   <= w_pl[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_adv) begin
      r_valid <= {r_valid[LOG:0], in_valid};
      r_sum   <= w_sum;
      r_cout  <= w_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (r_valid[LOG+1] && out_ready) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_kogge_stone_pipe.sv
// Directed bench for kogge_stone_pipe at WIDTH=16, APPROX_MAX=8.
module tb_kogge_stone_pipe;
  localparam int WIDTH      = 16;
  localparam int APPROX_MAX = 8;
  localparam int KW         = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              cin = 1'b0;
  logic [KW-1:0]     approx_k = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic [31:0]       op_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kogge_stone_pipe #(.WIDTH(WIDTH), .APPROX_MAX(APPROX_MAX), .KW(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_k(approx_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact add for k=0, otherwise OR low part plus carry a[k-1]&b[k-1].
  function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic [3:0] mk);
    int          k;
    logic [15:0] mask;
    logic [15:0] lo;
    logic [16:0] hi;
    logic        c;
    k = (mk > 4'd8) ? 8 : int'(mk);
    if (k == 0) return {1'b0, ma} + {1'b0, mb} + 17'(mc);
    mask = 16'((1 << k) - 1);
    lo   = (ma | mb) & mask;
    c    = ma[k-1] & mb[k-1];
    hi   = 17'(ma >> k) + 17'(mb >> k) + 17'(c);
    return (hi << k) | {1'b0, lo};
  endfunction

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_sum", {cout, sum}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);
  endtask

  task automatic send_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic [3:0] tk,
                          input logic [15:0] exp_sum, input logic exp_cout, input int exp_cnt);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; approx_k = tk; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 6);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    @(posedge clk); #1;
    check({tag, "_cnt"}, op_count, exp_cnt);
    check({tag, "_drained"}, out_valid, 0);
  endtask

  task automatic stream_test();
    logic [15:0] va [10];
    logic [15:0] vb [10];
    logic        vc [10];
    logic [3:0]  vk [10];
    logic [16:0] expq [$];
    logic [16:0] held;
    logic        held_ok;
    int issued, recv, cyc, stalls;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; vk[0] = 4'd0;
    va[1] = 16'h00FF; vb[1] = 16'h00FF; vc[1] = 1'b1; vk[1] = 4'd15;
    for (int i = 2; i < 10; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom);
      vk[i] = 4'($urandom_range(0, 15));
    end
    issued = 0; recv = 0; cyc = 0; stalls = 0; held = '0; held_ok = 1'b0;
    while (recv < 10 && cyc < 200) begin
      out_ready = !(cyc >= 8 && cyc <= 12);
      if (issued < 10) begin
        in_valid = 1'b1;
        a = va[issued]; b = vb[issued]; cin = vc[issued]; approx_k = vk[issued];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        stalls++;
        check("stall_in_ready", in_ready, 0);
        if (held_ok) check("stall_hold", {cout, sum}, held);
        held = {cout, sum};
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin, approx_k));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("stream_extra", 1, 0);
        else check($sformatf("stream_%0d", recv), {cout, sum}, expq.pop_front());
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_done", recv, 10);
    check("stream_stalls", stalls, 5);
    check("stream_cnt", op_count, 10);
    check("stream_no_dup", out_valid, 0);
  endtask

  task automatic midflight_reset();
    int seen;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'(16'h1111 * (i + 1)); b = 16'h0F0F; cin = 1'b0; approx_k = 4'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_op_count", op_count, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    @(posedge clk); #1;
    check("midrst_ghosts", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(2);
    send_one("wrap",     16'hFFFF, 16'h0001, 1'b0, 4'd0,  16'h0000, 1'b1, 1);
    send_one("cin",      16'h1234, 16'h4321, 1'b1, 4'd0,  16'h5556, 1'b0, 2);
    send_one("approx4",  16'h00FF, 16'h0001, 1'b1, 4'd4,  16'h00FF, 1'b0, 3);
    send_one("clamp",    16'h00FF, 16'h00FF, 1'b0, 4'd15, 16'h01FF, 1'b0, 4);
    send_one("approx8c", 16'hFF80, 16'h0080, 1'b0, 4'd8,  16'h0080, 1'b1, 5);
    send_one("approx2",  16'h0002, 16'h0003, 1'b1, 4'd2,  16'h0007, 1'b0, 6);

    do_reset(1);
    stream_test();

    midflight_reset();
    send_one("post_rst", 16'h1234, 16'h4321, 1'b1, 4'd0, 16'h5556, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
